// File: rtl/aes_bist_ctrl_if.sv
// -----------------------------------------------------------------------------
// aes_bist_ctrl_if
// Bundles the control/status handshake between the AES BIST sequencer, the
// BIST wrapper around the AES core and the system controller.
//
//   start, abort        system controller -> sequencer requests
//   dut_done, sig_in    BIST wrapper -> sequencer (DONE and d_out/MISR)
//   is_bist,
//   en_lsfr_misr        sequencer -> BIST wrapper controls
//   busy, bist_done,
//   bist_pass,
//   bist_timeout,
//   sig_out, blk_cnt    sequencer -> system controller status
//
// Modports: master = the sequencer itself, slave = everything around it.
// -----------------------------------------------------------------------------
interface aes_bist_ctrl_if;
    logic       start;
    logic       abort;
    logic       dut_done;
    logic [7:0] sig_in;
    logic       is_bist;
    logic       en_lsfr_misr;
    logic       busy;
    logic       bist_done;
    logic       bist_pass;
    logic       bist_timeout;
    logic [7:0] sig_out;
    logic [7:0] blk_cnt;

    modport master (
        input  start, abort, dut_done, sig_in,
        output is_bist, en_lsfr_misr, busy, bist_done,
               bist_pass, bist_timeout, sig_out, blk_cnt
    );

    modport slave (
        output start, abort, dut_done, sig_in,
        input  is_bist, en_lsfr_misr, busy, bist_done,
               bist_pass, bist_timeout, sig_out, blk_cnt
    );
endinterface

// File: rtl/aes_bist_ctrl.sv
// -----------------------------------------------------------------------------
// aes_bist_ctrl
// Sequences one built-in self-test of the AES core through its BIST wrapper:
// selects LFSR stimulus (is_bist), runs the LFSR/MISR (en_lsfr_misr) until
// NUM_BLOCKS rising edges of the wrapper's DONE are seen, lets the MISR take
// the final byte, then captures the signature and compares it to GOLDEN_SIG.
// A RUN phase longer than TIMEOUT cycles ends the test with bist_timeout set.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous reset, active low
//   bus   aes_bist_ctrl_if.master (requests in, wrapper controls and
//         status out; all outputs are flops)
// -----------------------------------------------------------------------------
module aes_bist_ctrl #(
    parameter logic [7:0] GOLDEN_SIG = 8'hC0,
    parameter int         NUM_BLOCKS = 1,
    parameter int         TIMEOUT    = 1023,
    parameter int         CNT_W      = 10
) (
    input  logic             clk,
    input  logic             rst,
    aes_bist_ctrl_if.master  bus
);

    localparam logic [CNT_W-1:0] TMO_VAL  = CNT_W'(TIMEOUT);
    localparam logic [7:0]       NBLK_VAL = 8'(NUM_BLOCKS);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_RUN    = 3'd2,
        ST_SETTLE = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Control outputs belonging to a state: {is_bist, en, busy, done}.
    // Loaded together with the state so they are flops, not decode logic.
    function automatic logic [3:0] state_outs(input state_t st);
        logic [3:0] o;
        case (st)
            ST_IDLE:   o = 4'b0000;
            ST_ARM:    o = 4'b1010;
            ST_RUN:    o = 4'b1110;
            ST_SETTLE: o = 4'b1110;
            ST_CHECK:  o = 4'b1010;
            ST_DONE:   o = 4'b1001;
            default:   o = 4'b0000;
        endcase
        return o;
    endfunction

    state_t           state_r;
    logic [3:0]       ctl_r;
    logic [CNT_W-1:0] cyc_cnt_r;
    logic [7:0]       blk_cnt_r;
    logic [7:0]       sig_r;
    logic             pass_r;
    logic             tmo_r;
    logic             dut_prev_r;
    logic             dut_edge_s;

    // Rising edge of the wrapper's DONE against last cycle's sample.
    always_comb begin
        dut_edge_s = bus.dut_done & ~dut_prev_r;
    end

    // Sequencer state, counters and captured results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            ctl_r      <= 4'b0000;
            cyc_cnt_r  <= '0;
            blk_cnt_r  <= 8'd0;
            sig_r      <= 8'd0;
            pass_r     <= 1'b0;
            tmo_r      <= 1'b0;
            dut_prev_r <= 1'b0;
        end else begin
            // Sampled every cycle, so ARM preloads it and a DONE that is
            // already high when RUN starts is not taken as an edge.
            dut_prev_r <= bus.dut_done;
            if (bus.abort) begin
                state_r   <= ST_IDLE;
                ctl_r     <= state_outs(ST_IDLE);
                cyc_cnt_r <= '0;
                blk_cnt_r <= 8'd0;
                sig_r     <= 8'd0;
                pass_r    <= 1'b0;
                tmo_r     <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE, ST_DONE: begin
                        if (bus.start) begin
                            state_r   <= ST_ARM;
                            ctl_r     <= state_outs(ST_ARM);
                            cyc_cnt_r <= '0;
                            blk_cnt_r <= 8'd0;
                            sig_r     <= 8'd0;
                            pass_r    <= 1'b0;
                            tmo_r     <= 1'b0;
                        end else begin
                            state_r <= state_r;
                        end
                    end
                    ST_ARM: begin
                        state_r <= ST_RUN;
                        ctl_r   <= state_outs(ST_RUN);
                    end
                    ST_RUN: begin
                        // Saturate rather than wrap so the timeout stays sticky.
                        if (cyc_cnt_r != TMO_VAL) begin
                            cyc_cnt_r <= cyc_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        end else begin
                            cyc_cnt_r <= cyc_cnt_r;
                        end
                        if (dut_edge_s) begin
                            blk_cnt_r <= blk_cnt_r + 8'd1;
                        end else begin
                            blk_cnt_r <= blk_cnt_r;
                        end
                        // The final block edge outranks a coincident timeout.
                        if (dut_edge_s && ((blk_cnt_r + 8'd1) == NBLK_VAL)) begin
                            state_r <= ST_SETTLE;
                            ctl_r   <= state_outs(ST_SETTLE);
                        end else if (cyc_cnt_r == TMO_VAL) begin
                            state_r <= ST_DONE;
                            ctl_r   <= state_outs(ST_DONE);
                            sig_r   <= bus.sig_in;
                            pass_r  <= 1'b0;
                            tmo_r   <= 1'b1;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end
                    ST_SETTLE: begin
                        state_r <= ST_CHECK;
                        ctl_r   <= state_outs(ST_CHECK);
                    end
                    ST_CHECK: begin
                        state_r <= ST_DONE;
                        ctl_r   <= state_outs(ST_DONE);
                        sig_r   <= bus.sig_in;
                        pass_r  <= (bus.sig_in == GOLDEN_SIG);
                        tmo_r   <= 1'b0;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        ctl_r   <= state_outs(ST_IDLE);
                    end
                endcase
            end
        end
    end

    assign bus.is_bist      = ctl_r[3];
    assign bus.en_lsfr_misr = ctl_r[2];
    assign bus.busy         = ctl_r[1];
    assign bus.bist_done    = ctl_r[0];
    assign bus.bist_pass    = pass_r;
    assign bus.bist_timeout = tmo_r;
    assign bus.sig_out      = sig_r;
    assign bus.blk_cnt      = blk_cnt_r;

endmodule

// File: doc/aes_bist_ctrl.md
Name: aes_bist_ctrl

Overview:
- Sequences a built-in self-test of the 8-bit-path AES core through the BIST wrapper that muxes LFSR key/data into the core and compacts its output in a MISR.
- Sits directly upstream of that wrapper: drives is_bist and en_lsfr_misr, counts completed blocks via DONE, then samples the MISR signature on d_out and compares it with a golden value.
- Reports done/pass/timeout to the system controller.

Parameters:
- GOLDEN_SIG, 8'hC0, expected MISR signature after NUM_BLOCKS blocks
- NUM_BLOCKS, 1, AES blocks to run before checking (1..255)
- TIMEOUT, 1023, maximum RUN cycles before aborting with timeout (must be < 2**CNT_W)
- CNT_W, 10, width of the RUN cycle counter

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous reset, active-low
- start  in  1  single-cycle request to begin a test; honoured only in IDLE or DONE
- abort  in  1  synchronous abort; returns the block to IDLE
- dut_done  in  1  DONE from the BIST wrapper; its rising edge marks one completed block
- sig_in  in  8  d_out from the BIST wrapper (MISR signature while is_bist=1)
- is_bist  out  1  selects LFSR stimulus and MISR output in the wrapper
- en_lsfr_misr  out  1  LFSR/MISR advance enable
- busy  out  1  high in ARM, RUN, SETTLE and CHECK
- bist_done  out  1  high in DONE
- bist_pass  out  1  valid while bist_done=1
- bist_timeout  out  1  valid while bist_done=1
- sig_out  out  8  captured signature, held in DONE
- blk_cnt  out  8  blocks completed in the current test

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs are 0, including sig_out, blk_cnt, the cycle counter and the dut_done edge register.
- All outputs are registered or decoded purely from state. No combinational input-to-output paths.
- IDLE: is_bist=0, en=0. start=1 -> ARM; also clears blk_cnt, the cycle counter, pass, timeout and sig_out.
- ARM (1 cycle): is_bist=1, en=0. Lets the input mux settle. -> RUN.
- RUN: is_bist=1, en=1.
  - The cycle counter increments every cycle.
  - Rising-edge detect on dut_done (registered previous value) increments blk_cnt.
  - blk_cnt reaches NUM_BLOCKS on this edge -> SETTLE.
  - Otherwise, cycle counter == TIMEOUT -> DONE with timeout=1, pass=0, sig_out=sig_in.
  - A dut_done edge and the timeout in the same cycle: the block count wins, go to SETTLE.
- SETTLE (1 cycle): is_bist=1, en=1. The MISR absorbs the last output byte. -> CHECK.
- CHECK (1 cycle): is_bist=1, en=0. sig_out<=sig_in; pass<=(sig_in==GOLDEN_SIG); timeout<=0. -> DONE.
- DONE: is_bist=1, en=0, so the wrapper keeps showing the signature. bist_done=1; results are held.
  - start=1 -> ARM and clears all results, the same as from IDLE.
- Cycle-level sequence from a start pulse at cycle 0:
  - cycles 1–2: busy=1 (ARM); cycle 2: en=1 (RUN).
  - First dut_done edge seen in cycle N: SETTLE at N+1, CHECK at N+2, bist_done=1 from N+3.
- start while busy=1 is ignored.
- abort=1 in any state -> IDLE next cycle, all results cleared. abort has priority over start in the same cycle.
- The cycle counter saturates at TIMEOUT and never wraps.
- blk_cnt never exceeds NUM_BLOCKS.
- dut_done held high does not count again until it has fallen and risen again.
- dut_done already high on entry to RUN does not count: the edge register is loaded with dut_done in ARM.
- Reset asserted mid-test returns to IDLE immediately. There is no recovery of a partial test.

Test Plan:
- Reset, then a start pulse; dut_done rises at RUN cycle 40 with sig_in=8'hC0 -> blk_cnt=1, SETTLE, CHECK, then bist_done=1, bist_pass=1, bist_timeout=0, sig_out=8'hC0 three cycles after the edge; en_lsfr_misr high exactly from ARM+1 through SETTLE.
- Same flow with sig_in=8'h3E at CHECK -> bist_done=1, bist_pass=0, sig_out=8'h3E.
- TIMEOUT=20, dut_done never rises -> bist_done=1 after ARM plus 21 RUN cycles, bist_timeout=1, bist_pass=0.
- NUM_BLOCKS=3, dut_done pulses three times, with one pulse held high for 5 cycles -> blk_cnt counts 1, 2, 3 only; SETTLE follows the third edge.
- abort asserted in RUN together with start -> IDLE next cycle, is_bist=0, busy=0, blk_cnt=0; a later start runs normally.
- rst driven low between clock edges during RUN -> outputs go to 0 without waiting for a clock edge; start pulses while busy are ignored (blk_cnt and state unaffected).
